// File: rtl/reaction_controller.sv
// Reaction-game sequencer: arms the delay, times the press, loads the score. Define REACTION_FALSE_START_EN to enable false-start detection.
// Latency: button edge to state/output change is 4 cycles (2 sync + 1 edge + 1 registered state); strobes are held TICK_DIV+1 cycles.
// Backpressure: none; the datapath must accept every strobe, which is stretched so at least one ms tick samples it.
module reaction_controller #(
  parameter int TICK_DIV   = 50000,
  parameter int MAX_MS     = 2000,
  parameter int SHOW_TICKS = 3000
) (
  input  logic        clk,
  input  logic        iReset,
  input  logic        iButton,
  input  logic        iCountComplete,
  input  logic [11:0] iUpCount,
  output logic        oStart_down_count,
  output logic        oStart_up_count,
  output logic        oLoad_score,
  output logic [1:0]  oScreen,
  output logic        oLamp,
  output logic        oFalse_start,
  output logic        oBusy
);

  localparam int SW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_GO_ARM,
    S_MEASURE,
    S_LOAD,
`ifdef REACTION_FALSE_START_EN
    S_RESULT,
    S_FALSE
`else
    S_RESULT
`endif
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_sync0, r_sync1, r_sync2, r_btn_rise;
  logic [16:0]   r_hold;
  logic [SW-1:0] r_show;
  logic          r_pressed;
  logic          w_hold_done, w_show_done, w_in_show;
  logic [1:0]    w_screen;
  logic          r_down, r_up, r_load, r_lamp, r_busy;
  logic [1:0]    r_screen;

  assign w_hold_done = (r_hold == 17'd0);
  assign w_show_done = w_hold_done && (r_show == SW'(SHOW_TICKS - 1));
`ifdef REACTION_FALSE_START_EN
  assign w_in_show = (r_state == S_RESULT) || (r_state == S_FALSE);
`else
  assign w_in_show = (r_state == S_RESULT);
`endif

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      r_sync0    <= 1'b0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_btn_rise <= 1'b0;
    end else begin
      r_sync0    <= iButton;
      r_sync1    <= r_sync0;
      r_sync2    <= r_sync1;
      r_btn_rise <= r_sync1 & ~r_sync2;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (r_btn_rise) w_next = S_ARM;
      // iCountComplete is stale while the down counter reloads, so ARM only watches its hold.
      S_ARM:     if (w_hold_done) w_next = S_WAIT;
      S_WAIT: begin
        if (iCountComplete) w_next = S_GO_ARM;
`ifdef REACTION_FALSE_START_EN
        else if (r_btn_rise) w_next = S_FALSE;
`endif
      end
      S_GO_ARM:  if (w_hold_done) w_next = (r_pressed || r_btn_rise) ? S_LOAD : S_MEASURE;
      S_MEASURE: begin
        if (r_btn_rise) w_next = S_LOAD;
        else if (iUpCount >= 12'(MAX_MS)) w_next = S_RESULT;
      end
      S_LOAD:    if (w_hold_done) w_next = S_RESULT;
      S_RESULT:  if (r_btn_rise || w_show_done) w_next = S_IDLE;
`ifdef REACTION_FALSE_START_EN
      S_FALSE:   if (r_btn_rise || w_show_done) w_next = S_IDLE;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_screen = 2'b11;
    case (w_next)
      S_IDLE:              w_screen = 2'b00;
      S_ARM, S_WAIT:       w_screen = 2'b01;
      S_GO_ARM, S_MEASURE: w_screen = 2'b10;
      default:             w_screen = 2'b11;
    endcase
  end

  // Hold counter doubles as the ms prescaler while a result screen is shown.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      r_state   <= S_IDLE;
      r_hold    <= 17'd0;
      r_show    <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state != w_next) begin
        r_show    <= '0;
        r_pressed <= 1'b0;
`ifdef REACTION_FALSE_START_EN
        if (w_next == S_RESULT || w_next == S_FALSE) r_hold <= 17'(TICK_DIV - 1);
`else
        if (w_next == S_RESULT) r_hold <= 17'(TICK_DIV - 1);
`endif
        else r_hold <= 17'(TICK_DIV);
      end else begin
        if (r_state == S_GO_ARM && r_btn_rise) r_pressed <= 1'b1;
        if (!w_hold_done) begin
          r_hold <= r_hold - 1'b1;
        end else if (w_in_show) begin
          r_hold <= 17'(TICK_DIV - 1);
          r_show <= r_show + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      r_down   <= 1'b0;
      r_up     <= 1'b0;
      r_load   <= 1'b0;
      r_lamp   <= 1'b0;
      r_busy   <= 1'b0;
      r_screen <= 2'b00;
    end else begin
      r_down   <= (w_next == S_ARM);
      r_up     <= (w_next == S_GO_ARM);
      r_load   <= (w_next == S_LOAD);
      r_lamp   <= (w_next == S_GO_ARM) || (w_next == S_MEASURE);
      r_busy   <= (w_next != S_IDLE);
      r_screen <= w_screen;
    end
  end

`ifdef REACTION_FALSE_START_EN
  logic r_false;
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) r_false <= 1'b0;
    else         r_false <= (w_next == S_FALSE);
  end
  assign oFalse_start = r_false;
`else
  assign oFalse_start = 1'b0;
`endif

  assign oStart_down_count = r_down;
  assign oStart_up_count   = r_up;
  assign oLoad_score       = r_load;
  assign oLamp             = r_lamp;
  assign oBusy             = r_busy;
  assign oScreen           = r_screen;

endmodule

// File: tb/tb_reaction_controller.sv
// Directed bench for reaction_controller with TICK_DIV=4, MAX_MS=20, SHOW_TICKS=3.
module tb_reaction_controller;

  logic        clk;
  logic        iReset;
  logic        iButton;
  logic        iCountComplete;
  logic [11:0] iUpCount;
  logic        oStart_down_count, oStart_up_count, oLoad_score, oLamp, oFalse_start, oBusy;
  logic [1:0]  oScreen;

  int n_checks = 0;
  int n_errors = 0;
  logic load_seen;

  reaction_controller #(.TICK_DIV(4), .MAX_MS(20), .SHOW_TICKS(3)) dut (
    .clk              (clk),
    .iReset           (iReset),
    .iButton          (iButton),
    .iCountComplete   (iCountComplete),
    .iUpCount         (iUpCount),
    .oStart_down_count(oStart_down_count),
    .oStart_up_count  (oStart_up_count),
    .oLoad_score      (oLoad_score),
    .oScreen          (oScreen),
    .oLamp            (oLamp),
    .oFalse_start     (oFalse_start),
    .oBusy            (oBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // IDLE -> ARM (5 cycles) -> WAIT -> GO_ARM; returns one cycle after GO_ARM entry.
  task automatic to_go_arm();
    iButton = 1'b1;
    tick(4);
    iButton = 1'b0;
    tick(5);
    iCountComplete = 1'b1;
    tick(1);
    iCountComplete = 1'b0;
  endtask

  initial begin
    iReset = 1'b0; iButton = 1'b0; iCountComplete = 1'b0; iUpCount = 12'd0;
    tick(3);
    chk("rst_screen", oScreen, 2'b00);
    chk("rst_busy", oBusy, 0);
    chk("rst_down", oStart_down_count, 0);
    chk("rst_up", oStart_up_count, 0);
    chk("rst_load", oLoad_score, 0);
    chk("rst_lamp", oLamp, 0);
    chk("rst_false", oFalse_start, 0);
    iReset = 1'b1;
    tick(3);
    chk("idle_busy", oBusy, 0);

    // reset asserted in the middle of ARM
    iButton = 1'b1;
    tick(4);
    chk("arm_down", oStart_down_count, 1);
    chk("arm_busy", oBusy, 1);
    tick(2);
    iButton = 1'b0;
    iReset = 1'b0;
    #1;
    chk("midrst_down", oStart_down_count, 0);
    chk("midrst_screen", oScreen, 2'b00);
    chk("midrst_busy", oBusy, 0);
    tick(1);
    iReset = 1'b1;
    tick(10);
    chk("postrst_screen", oScreen, 2'b00);
    chk("postrst_busy", oBusy, 0);

    // full arm sequence, button held through ARM into WAIT
    iButton = 1'b1;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("down_hold%0d", i), oStart_down_count, 1);
      chk($sformatf("arm_screen%0d", i), oScreen, 2'b01);
      tick(1);
    end
    chk("down_end", oStart_down_count, 0);
    chk("wait_screen", oScreen, 2'b01);
    tick(5);
    chk("held_no_retrig", oScreen, 2'b01);
    iButton = 1'b0;
    tick(2);
    iCountComplete = 1'b1;
    tick(1);
    iCountComplete = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("up_hold%0d", i), oStart_up_count, 1);
      chk($sformatf("goarm_lamp%0d", i), oLamp, 1);
      chk($sformatf("goarm_screen%0d", i), oScreen, 2'b10);
      tick(1);
    end
    chk("up_end", oStart_up_count, 0);
    chk("meas_lamp", oLamp, 1);
    chk("meas_screen", oScreen, 2'b10);

    // press in MEASURE: load 4 cycles after edge, held 5, result for 12 cycles
    iUpCount = 12'd7;
    iButton = 1'b1;
    tick(3);
    chk("load_early", oLoad_score, 0);
    tick(1);
    iButton = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("load_hold%0d", i), oLoad_score, 1);
      chk($sformatf("load_screen%0d", i), oScreen, 2'b11);
      tick(1);
    end
    chk("load_end", oLoad_score, 0);
    chk("result_screen", oScreen, 2'b11);
    iUpCount = 12'd0;
    tick(11);
    chk("result_last", oScreen, 2'b11);
    tick(1);
    chk("result_expire", oScreen, 2'b00);
    chk("result_busy", oBusy, 0);

    // timeout without press
    to_go_arm();
    tick(5);
    chk("to_meas_screen", oScreen, 2'b10);
    load_seen = 1'b0;
    for (int v = 0; v <= 20; v++) begin
      iUpCount = 12'(v);
      tick(1);
      load_seen = load_seen | oLoad_score;
    end
    chk("timeout_screen", oScreen, 2'b11);
    chk("timeout_busy", oBusy, 1);
    iUpCount = 12'd0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      load_seen = load_seen | oLoad_score;
    end
    chk("timeout_idle", oScreen, 2'b00);
    chk("timeout_noload", load_seen, 0);

    // press while in WAIT
    iButton = 1'b1;
    tick(4);
    iButton = 1'b0;
    tick(5);
    chk("fs_wait", oScreen, 2'b01);
    tick(2);
    iButton = 1'b1;
    tick(4);
    iButton = 1'b0;
`ifdef REACTION_FALSE_START_EN
    chk("fs_flag", oFalse_start, 1);
    chk("fs_screen", oScreen, 2'b11);
    chk("fs_noload", oLoad_score, 0);
    tick(11);
    chk("fs_last", oScreen, 2'b11);
    tick(1);
    chk("fs_expire", oScreen, 2'b00);
    chk("fs_clear", oFalse_start, 0);
`else
    chk("nofs_flag", oFalse_start, 0);
    chk("nofs_screen", oScreen, 2'b01);
    chk("nofs_busy", oBusy, 1);
    iReset = 1'b0;
    tick(1);
    iReset = 1'b1;
    tick(1);
    chk("nofs_reset", oScreen, 2'b00);
`endif

    // same-cycle btn_rise and iCountComplete in WAIT
    iButton = 1'b1;
    tick(4);
    iButton = 1'b0;
    tick(5);
    iButton = 1'b1;
    tick(3);
    iCountComplete = 1'b1;
    tick(1);
    iCountComplete = 1'b0;
    chk("tie_screen", oScreen, 2'b10);
    chk("tie_up", oStart_up_count, 1);
    chk("tie_false", oFalse_start, 0);
    tick(5);
    chk("tie_meas_screen", oScreen, 2'b10);
    chk("tie_meas_up", oStart_up_count, 0);
    chk("tie_meas_load", oLoad_score, 0);
    iButton = 1'b0;
    tick(2);

    // same-cycle btn_rise and timeout in MEASURE, then press to leave RESULT
    iButton = 1'b1;
    tick(3);
    iUpCount = 12'd20;
    tick(1);
    chk("tie2_load", oLoad_score, 1);
    chk("tie2_screen", oScreen, 2'b11);
    iUpCount = 12'd0;
    iButton = 1'b0;
    tick(6);
    chk("tie2_result", oScreen, 2'b11);
    iButton = 1'b1;
    tick(4);
    iButton = 1'b0;
    chk("result_press_idle", oScreen, 2'b00);
    chk("result_press_busy", oBusy, 0);
    tick(2);

    // press during GO_ARM loads once the hold completes
    to_go_arm();
    iButton = 1'b1;
    tick(4);
    chk("goarm_press_hold", oStart_up_count, 1);
    tick(1);
    iButton = 1'b0;
    chk("goarm_press_load", oLoad_score, 1);
    chk("goarm_press_screen", oScreen, 2'b11);
    tick(17);
    chk("goarm_press_idle", oScreen, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
